// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// progress width helper, default pattern and overlap mode encoding.
package seq_det_pkg;

    localparam int MIN_PAT_W = 2;
    localparam int MAX_PAT_W = 16;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } overlap_mode_e;

    // Progress runs 0..patW inclusive, so it needs room for patW+1 values.
    function automatic int progressWidth(input int patW);
        return $clog2(patW + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational next-progress computation: parallel compare of every suffix
// of the window against the same-length pattern prefix, largest hit wins.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter  int PAT_W  = 4,
    localparam int PROG_W = progressWidth(PAT_W)
) (
    input  logic [PAT_W-1:0]  i_window,
    input  logic [PAT_W-1:0]  i_pattern,
    input  logic [PROG_W-1:0] i_progress,
    input  overlap_mode_e     i_mode,
    output logic [PROG_W-1:0] o_nextProgress
);

    logic [PAT_W-1:0] w_hit;

    // w_hit[k-1]: the newest k window bits equal the first k pattern bits.
    for (genvar k = 1; k <= PAT_W; k++) begin : gHit
        assign w_hit[k-1] = (i_window[k-1:0] == i_pattern[PAT_W-1 -: k]);
    end

    always_comb begin
        int limit;
        limit          = int'(i_progress) + 1;
        o_nextProgress = '0;
        if (limit > PAT_W) begin
            limit = PAT_W;
        end
        // A completed non-overlapping match may not reuse any of its bits.
        if ((i_mode == MODE_NON_OVERLAP) && (int'(i_progress) == PAT_W)) begin
            o_nextProgress = (i_window[0] == i_pattern[PAT_W-1]) ? PROG_W'(1) : '0;
        end else begin
            for (int k = 1; k <= PAT_W; k++) begin
                if (w_hit[k-1] && (k <= limit)) begin
                    o_nextProgress = PROG_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// Moore match flag, progress output and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter  int               PAT_W         = 4,
    parameter  int               CNT_W         = 8,
    parameter  logic [PAT_W-1:0] RESET_PATTERN = PAT_W'(DEFAULT_PATTERN),
    localparam int               PROG_W        = progressWidth(PAT_W)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pattern_load,
    input  logic [PAT_W-1:0]  pattern_in,
    input  logic              overlap_en,
    input  logic              sequence_valid,
    input  logic              sequence_in,
    input  logic              count_clear,
    output logic              detector_out,
    output logic [PROG_W-1:0] progress,
    output logic [CNT_W-1:0]  match_count
);

    if ((PAT_W < MIN_PAT_W) || (PAT_W > MAX_PAT_W)) begin : gBadPatW
        $error("seq_pattern_detector: PAT_W must be within 2..16");
    end

    localparam logic [PROG_W-1:0] FULL_PROGRESS = PROG_W'(PAT_W);
    localparam logic [CNT_W-1:0]  COUNT_MAX     = '1;

    logic [PAT_W-1:0]  r_pattern;
    overlap_mode_e     r_mode;
    logic [PAT_W-2:0]  r_history;
    logic [PROG_W-1:0] r_progress;
    logic [CNT_W-1:0]  r_count;

    logic [PAT_W-1:0]  w_window;
    logic [PROG_W-1:0] w_nextProgress;
    logic              w_enterMatch;

    assign w_window = {r_history, sequence_in};

    seq_prefix_match #(
        .PAT_W (PAT_W)
    ) u_prefixMatch (
        .i_window       (w_window),
        .i_pattern      (r_pattern),
        .i_progress     (r_progress),
        .i_mode         (r_mode),
        .o_nextProgress (w_nextProgress)
    );

    // A load takes priority and swallows any bit presented alongside it.
    assign w_enterMatch = sequence_valid && !pattern_load &&
                          (w_nextProgress == FULL_PROGRESS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern  <= RESET_PATTERN;
            r_mode     <= MODE_OVERLAP;
            r_history  <= '0;
            r_progress <= '0;
        end else if (pattern_load) begin
            r_pattern  <= pattern_in;
            r_mode     <= overlap_mode_e'(overlap_en);
            r_history  <= '0;
            r_progress <= '0;
        end else if (sequence_valid) begin
            r_history  <= w_window[PAT_W-2:0];
            r_progress <= w_nextProgress;
        end
    end

    // A clear coinciding with a new match leaves that match counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (count_clear) begin
            r_count <= w_enterMatch ? CNT_W'(1) : '0;
        end else if (w_enterMatch && (r_count != COUNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign progress     = r_progress;
    assign detector_out = (r_progress == FULL_PROGRESS);
    assign match_count  = r_count;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector (PAT_W=4, CNT_W=2): the driver
// queues hand-computed post-edge state, a monitor pops and compares it.
module tb_seq_pattern_detector;

    localparam int PAT_W  = 4;
    localparam int CNT_W  = 2;
    localparam int PROG_W = $clog2(PAT_W + 1);

    typedef struct {
        int    prog;
        int    cnt;
        string name;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              pattern_load;
    logic [PAT_W-1:0]  pattern_in;
    logic              overlap_en;
    logic              sequence_valid;
    logic              sequence_in;
    logic              count_clear;
    logic              detector_out;
    logic [PROG_W-1:0] progress;
    logic [CNT_W-1:0]  match_count;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    seq_pattern_detector #(
        .PAT_W         (PAT_W),
        .CNT_W         (CNT_W),
        .RESET_PATTERN (4'b1011)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pattern_load   (pattern_load),
        .pattern_in     (pattern_in),
        .overlap_en     (overlap_en),
        .sequence_valid (sequence_valid),
        .sequence_in    (sequence_in),
        .count_clear    (count_clear),
        .detector_out   (detector_out),
        .progress       (progress),
        .match_count    (match_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; the expected state after the edge is queued.
    task automatic applyStimulus(input string name, input logic load, input logic [PAT_W-1:0] pat,
                                 input logic ov, input logic valid, input logic bitIn,
                                 input logic clr, input int expProg, input int expCnt);
        exp_t e;
        @(negedge clock);
        pattern_load   = load;
        pattern_in     = pat;
        overlap_en     = ov;
        sequence_valid = valid;
        sequence_in    = bitIn;
        count_clear    = clr;
        @(posedge clock);
        #1;
        e.prog = expProg;
        e.cnt  = expCnt;
        e.name = name;
        expQ.push_back(e);
    endtask

    task automatic bitIn(input string name, input logic b, input int p, input int c);
        applyStimulus(name, 1'b0, 4'h0, 1'b0, 1'b1, b, 1'b0, p, c);
    endtask

    task automatic idle(input string name, input logic b, input int p, input int c);
        applyStimulus(name, 1'b0, 4'h0, 1'b0, 1'b0, b, 1'b0, p, c);
    endtask

    task automatic loadPat(input string name, input logic [PAT_W-1:0] pat, input logic ov,
                           input logic valid, input logic b, input int c);
        applyStimulus(name, 1'b1, pat, ov, valid, b, 1'b1, 0, c);
    endtask

    // Monitor: registered outputs are compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, " progress"}, int'(progress), e.prog);
                checkOutput({e.name, " detector_out"}, int'(detector_out), (e.prog == PAT_W) ? 1 : 0);
                checkOutput({e.name, " match_count"}, int'(match_count), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        pattern_load   = 1'b0;
        pattern_in     = '0;
        overlap_en     = 1'b0;
        sequence_valid = 1'b0;
        sequence_in    = 1'b0;
        count_clear    = 1'b0;
        #3;
        checkOutput("reset progress", int'(progress), 0);
        checkOutput("reset detector_out", int'(detector_out), 0);
        checkOutput("reset match_count", int'(match_count), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset pattern 1011, overlap, stream 1011011.
        bitIn("ov b1", 1, 1, 0);
        bitIn("ov b2", 0, 2, 0);
        bitIn("ov b3", 1, 3, 0);
        bitIn("ov b4", 1, 4, 1);
        bitIn("ov b5", 0, 2, 1);
        bitIn("ov b6", 1, 3, 1);
        bitIn("ov b7", 1, 4, 2);

        // Non-overlap 1011, same stream.
        loadPat("nov load", 4'b1011, 1'b0, 1'b0, 1'b0, 0);
        bitIn("nov b1", 1, 1, 0);
        bitIn("nov b2", 0, 2, 0);
        bitIn("nov b3", 1, 3, 0);
        bitIn("nov b4", 1, 4, 1);
        bitIn("nov b5", 0, 0, 1);
        bitIn("nov b6", 1, 1, 1);
        bitIn("nov b7", 1, 1, 1);

        // Periodic 1111, overlap: back-to-back matches.
        loadPat("p1111 load", 4'b1111, 1'b1, 1'b0, 1'b0, 0);
        bitIn("p1111 b1", 1, 1, 0);
        bitIn("p1111 b2", 1, 2, 0);
        bitIn("p1111 b3", 1, 3, 0);
        bitIn("p1111 b4", 1, 4, 1);
        bitIn("p1111 b5", 1, 4, 2);
        bitIn("p1111 b6", 0, 0, 2);

        // Invalid gaps must not disturb progress.
        loadPat("gap load", 4'b1011, 1'b1, 1'b0, 1'b0, 0);
        bitIn("gap b1", 1, 1, 0);
        bitIn("gap b2", 0, 2, 0);
        idle("gap idle1", 1, 2, 0);
        idle("gap idle2", 1, 2, 0);
        idle("gap idle3", 1, 2, 0);
        bitIn("gap b3", 1, 3, 0);
        bitIn("gap b4", 1, 4, 1);
        idle("match hold1", 0, 4, 1);
        idle("match hold2", 1, 4, 1);

        // Load mid-match discards the coincident bit.
        loadPat("mid load", 4'b1011, 1'b1, 1'b0, 1'b0, 0);
        bitIn("mid b1", 1, 1, 0);
        bitIn("mid b2", 0, 2, 0);
        bitIn("mid b3", 1, 3, 0);
        applyStimulus("load 0110 bit1", 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        applyStimulus("load 0110 bit0", 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        bitIn("p0110 b1", 0, 1, 0);
        bitIn("p0110 b2", 1, 2, 0);
        bitIn("p0110 b3", 1, 3, 0);
        bitIn("p0110 b4", 0, 4, 1);

        // Saturation of the 2-bit counter and clear interactions.
        loadPat("sat load", 4'b1111, 1'b1, 1'b0, 1'b0, 0);
        bitIn("sat b1", 1, 1, 0);
        bitIn("sat b2", 1, 2, 0);
        bitIn("sat b3", 1, 3, 0);
        bitIn("sat m1", 1, 4, 1);
        bitIn("sat m2", 1, 4, 2);
        bitIn("sat m3", 1, 4, 3);
        bitIn("sat m4", 1, 4, 3);
        bitIn("sat m5", 1, 4, 3);
        applyStimulus("clear with match", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1);
        applyStimulus("clear alone", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0);
        bitIn("after clear", 1, 4, 1);

        // Asynchronous reset while detector_out is high.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset progress", int'(progress), 0);
        checkOutput("async reset detector_out", int'(detector_out), 0);
        checkOutput("async reset match_count", int'(match_count), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset restores pattern 1011 in overlap mode.
        bitIn("rst b1", 1, 1, 0);
        bitIn("rst b2", 0, 2, 0);
        bitIn("rst b3", 1, 3, 0);
        bitIn("rst b4", 1, 4, 1);
        bitIn("rst b5", 0, 2, 1);
        bitIn("rst b6", 1, 3, 1);
        bitIn("rst b7", 1, 4, 2);

        repeat (3) @(negedge clock);
        #1;
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised, runtime-programmable serial sequence detector. It is the next generation of the fixed 5-state "1011" Moore detector. It watches a qualified 1-bit stream for a PAT_W-bit pattern loaded at run time, with selectable overlapping or non-overlapping matching. It exposes a Moore match flag, the current match progress, and a saturating match counter. It sits directly after the serial input sampler in the test-pattern datapath.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits, legal range 2..16.
- CNT_W, 8: width of the match counter.
- RESET_PATTERN, 4'b1011: pattern value after reset; width PAT_W.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clock.
- pattern_load  in  1  load pattern_in and overlap_en; restart detection.
- pattern_in  in  PAT_W  new pattern. Bit PAT_W-1 is the first bit expected on the stream.
- overlap_en  in  1  1 = overlapping matches, 0 = non-overlapping; captured only on pattern_load.
- sequence_valid  in  1  sequence_in is sampled only when this is high.
- sequence_in  in  1  serial data bit.
- count_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  Moore output: high while progress == PAT_W.
- progress  out  $clog2(PAT_W+1)  number of pattern bits currently matched, 0..PAT_W.
- match_count  out  CNT_W  completed matches, saturating at all-ones.

## Operation
- Reset values:
  - pattern = RESET_PATTERN
  - overlap mode = 1
  - history = 0
  - progress = 0
  - detector_out = 0
  - match_count = 0
- Logical states are progress values S0..S_PAT_W. S_PAT_W is the match state; detector_out = (progress == PAT_W).
- Priority each cycle: pattern_load, then sequence_valid, then hold.
- On pattern_load:
  - pattern and mode are registered.
  - progress and history are cleared.
  - A sequence bit presented in the same cycle is discarded.
- When sequence_valid is high, w = {history, sequence_in}.
  - Overlap mode, or progress < PAT_W: next progress is the largest k ≤ min(progress+1, PAT_W) such that the last k bits of w equal pattern[PAT_W-1 -: k]. Next progress is 0 if no such k exists (KMP-style fallback).
  - Non-overlap mode with progress == PAT_W: history is discarded. Next progress = 1 if sequence_in == pattern[PAT_W-1], else 0.
  - history shifts left, taking in sequence_in; it keeps the last PAT_W-1 bits.
- When sequence_valid is low: progress, history and detector_out hold. detector_out stays high if already high.
- match_count increments on every transition into S_PAT_W. This includes S_PAT_W → S_PAT_W in overlap mode with a periodic pattern such as 1111.
- match_count holds at all-ones once saturated.
- count_clear and an increment in the same cycle give match_count = 1.

## Timing
- detector_out is registered. It rises on the clock edge that samples the final pattern bit and is visible in the following cycle, matching the original Moore detector.
- Latency: 1 cycle from the last valid bit to detector_out / match_count update.
- Throughput: one bit per cycle. No back-pressure; sequence_valid may toggle arbitrarily.
- reset_n low mid-match forces all outputs to their reset values immediately, without waiting for a clock edge.
- pattern_load mid-match drops detector_out the next cycle. match_count is unaffected.

## Structure
- Shared package seq_det_pkg holds:
  - the progress width function
  - the default pattern constant
  - the overlap/non-overlap mode enum
- Sub-module seq_prefix_match (combinational) computes next progress from w, pattern, progress, and mode. It is a parallel compare across k = 1..PAT_W with a priority select of the largest hit.
- The top level holds the pattern/mode/history/progress registers and the counter.

## Test plan
- Reset pattern 1011, overlap, valid stream 1,0,1,1,0,1,1 → detector_out high in the cycles after bits 4 and 7; match_count = 2; progress after bit 5 = 2.
- Same stream, non-overlap (load 1011 with overlap_en=0) → a single match after bit 4; match_count = 1.
- Load 1111, overlap, five 1s → matches after bits 4 and 5; detector_out stays high for 2 cycles; match_count = 2.
- Pattern 1011 with sequence_valid low for 3 cycles between bits 2 and 3 → progress holds at 2; match still detected after bit 4; invalid bits with sequence_in=1 are ignored.
- At progress 3, assert pattern_load (0110) together with sequence_in=1 valid → progress = 0 next cycle; no match; the bit is discarded.
- CNT_W=2: drive 5 matches → match_count saturates at 3. count_clear coinciding with a match → match_count = 1. reset_n low while detector_out is high → outputs zero with no clock edge required.
